bn_shift_loader: RTL
====================

// Module: bn_shift_loader
// PURPOSE
//  Writable store for the BN1 per-channel shift constants, replacing the fixed constant table.
//  Accepts a byte stream (valid/ready) from the RISC-V SoC side and writes it sequentially into a DEPTH x DATA_W array.
//  Exposes the same combinational read port (rd_addr -> rd_data) that the CNN engine BN stage uses.
//  Tracks progress, computes an XOR checksum over the loaded bytes, and flags completion.
// PARAMETERS
//  DEPTH   32  number of shift entries (one per channel)
//  DATA_W  8   width of one shift entry
//  ADDR_W  6   width of rd_addr and wr_count (must satisfy 2**ADDR_W > DEPTH)
// PORTS
//  clk       in   1       system clock, rising edge
//  rst       in   1       asynchronous active-high reset
//  start     in   1       1-cycle pulse: begin a new load at entry 0
//  s_valid   in   1       stream byte valid
//  s_data    in   DATA_W  stream byte
//  s_ready   out  1       stream ready; a transfer occurs when s_valid && s_ready
//  busy      out  1       high while in LOAD
//  done      out  1       high from load completion until the next start or rst
//  wr_count  out  ADDR_W  number of entries written in the current load
//  checksum  out  DATA_W  XOR of all bytes accepted in the current load
//  rd_addr   in   ADDR_W  read address from the BN datapath
//  rd_data   out  DATA_W  shift value at rd_addr (combinational)
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=IDLE; all array entries=0.
//   - s_ready=0, busy=0, done=0, wr_count=0, checksum=0.
//  State machine IDLE / LOAD / DONE:
//   - IDLE: start -> LOAD; wr_count<=0, checksum<=0.
//   - LOAD: s_ready=1, busy=1.
//     - On each transfer: mem[wr_count]<=s_data, checksum<=checksum^s_data, wr_count<=wr_count+1.
//     - The transfer that writes entry DEPTH-1 moves to DONE in the same edge (wr_count=DEPTH, done=1 next cycle).
//   - DONE: s_ready=0, done=1. start -> LOAD with counters cleared (done falls the next cycle).
//  start while in LOAD:
//   - Restarts: wr_count<=0, checksum<=0, state stays LOAD.
//   - Any transfer in that same cycle is discarded (not written, not counted).
//  Array contents persist across loads; entries are overwritten only as new bytes arrive.
//  s_ready depends only on state, never combinationally on s_valid.
//  Upstream may hold s_valid high across cycles; every cycle with s_valid=1 in LOAD is one byte.
//  Read port:
//   - rd_data = mem[rd_addr] when rd_addr < DEPTH, else 0. Purely combinational, zero latency.
//   - Same-cycle write and read of the same entry returns the old value; the new value is visible the next cycle.
//   - Reads are legal in every state. The consumer gates its own use on done.
//  Throughput: one byte per cycle. A full load takes DEPTH cycles after start.
//  rst asserted mid-load aborts immediately; the array is cleared to 0.
// TESTING
//  T1 reset: rst=1 -> all outputs 0; rd_addr=0..31 read 0; rd_addr=40 reads 0.
//  T2 full load:
//   - start, then 32 back-to-back bytes 0x2b,0xc3,0x3c,... (BN1 shift set).
//   - Expect done=1 on the cycle after the 32nd byte, wr_count=32, checksum = XOR of all bytes.
//   - Expect rd_addr=1 -> 0xc3 and s_ready=0 in DONE.
//  T3 backpressure gaps:
//   - s_valid toggles randomly through the load.
//   - Expect only valid cycles written, in order; same final contents as T2.
//  T4 restart:
//   - start while in LOAD after 10 bytes, with s_valid=1 and s_data=0xAA that cycle.
//   - Expect wr_count=0, checksum=0, 0xAA not written; the next byte lands in entry 0.
//  T5 read/write collision:
//   - rd_addr=5 held while entry 5 is written 0x70 over old 0x11.
//   - Expect rd_data=0x11 that cycle, 0x70 the next.
//  T6 reset mid-load:
//   - rst pulsed after 16 bytes.
//   - Expect immediate IDLE, all entries 0, done=0; a subsequent full load behaves as in T2.

Source files
------------

// File: rtl/bn_shift_loader.sv
// Writable BN1 shift-constant store: loads a valid/ready byte stream sequentially
// into a DEPTH x DATA_W array and serves a zero-latency combinational read port.
module bn_shift_loader #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] wr_count,
  output logic [DATA_W-1:0] checksum,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              xfer;
  logic              clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A start in LOAD wins over a same-cycle transfer, so that byte is dropped.
  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    clear      = 1'b0;
    xfer       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_LOAD;
          clear      = 1'b1;
        end
      end
      S_LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (start) begin
          clear = 1'b1;
        end else if (s_valid) begin
          xfer = 1'b1;
          if (wr_count == LAST_IDX) begin
            next_state = S_DONE;
          end
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          next_state = S_LOAD;
          clear      = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count <= '0;
      checksum <= '0;
    end else if (clear) begin
      wr_count <= '0;
      checksum <= '0;
    end else if (xfer) begin
      wr_count <= wr_count + ADDR_W'(1);
      checksum <= checksum ^ s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (xfer) begin
      mem[wr_count[IDX_W-1:0]] <= s_data;
    end
  end

  // Out-of-range addresses read as zero rather than aliasing into the array.
  always_comb begin
    rd_data = '0;
    if (rd_addr < DEPTH_A) begin
      rd_data = mem[rd_addr[IDX_W-1:0]];
    end
  end

endmodule
